ddr4_cmd_sequencer: RTL
=======================

Name: ddr4_cmd_sequencer

Overview:
- Synthesizable DDR4 command sequencer that replaces hand-scripted stimulus with a request-driven front end for the dimm model.
- Takes one transaction at a time (write burst, read burst, or in-DRAM RowClone) over a valid/ready handshake.
- Issues the closed-page command stream ACT → WR/RD → PRE on the DDR4 pins, honouring parametrised timings.
- Drives write bursts and captures read bursts; sits between host/traffic logic and the dimm pins.

Parameters:
CHIPS, 18, devices per rank; dqs width
DEVICE_WIDTH, 4, bits per device; DQWIDTH = DEVICE_WIDTH*CHIPS
BGWIDTH, 2, bank-group address width
BAWIDTH, 2, bank address width
ADDRWIDTH, 17, row/A-bus width; must be 17
COLWIDTH, 10, column width; must be ≤10
BL, 8, burst length in beats
TRCD, 15, ACT→CAS cycles (≥1)
TCL, 15, RD CAS→first read beat (≥1)
TCWL, 12, WR CAS→first write beat (≥1)
TRAS, 32, ACT→PRE or ACT→ACT minimum
TWR, 16, last write beat→PRE
TRP, 15, PRE→ready

Ports:
ck_t in 1 clock, rising edge
reset_n in 1 async active-low reset
req_valid in 1 request valid
req_ready out 1 accepting requests
req_op in 2 01=write, 10=read, 11=rowclone, 00=reserved
req_bg in BGWIDTH bank group
req_ba in BAWIDTH bank
req_row in ADDRWIDTH row (RowClone source)
req_col in COLWIDTH column
req_dst_row in ADDRWIDTH RowClone destination row
req_wdata in DQWIDTH*BL write burst; beat k = [k*DQWIDTH +: DQWIDTH]
rd_valid out 1 one-cycle read-complete pulse
rd_data out DQWIDTH*BL captured read burst, same packing
done out 1 one-cycle pulse when PRE is issued
err out 1 one-cycle pulse for unsupported op
cs_n out 1 chip select, low only on command cycles
act_n out 1 ACT strobe
A out ADDRWIDTH address/command bus
bg out BGWIDTH bank group
ba out BAWIDTH bank
dq_out out DQWIDTH write data
dq_oe out 1 dq output enable
dq_in in DQWIDTH read data
dqs_t out CHIPS strobe true
dqs_c out CHIPS strobe complement

Behaviour:
- All outputs are registered. Cycle n is the n-th rising edge after the accepting edge (edge 0).
- Reset values (asynchronous): state=IDLE, req_ready=1, cs_n=1, act_n=1, A/bg/ba/dq_out=0, dq_oe=0, dqs_t=0, dqs_c=all 1, rd_valid/done/err=0, rd_data=0.
- Reset mid-operation aborts immediately; dq_oe drops with reset.
- A request is accepted when req_valid && req_ready. All req_* fields are latched on that edge. req_ready=1 only in IDLE; req_valid while busy is ignored.
- Non-command cycles: cs_n=1, act_n=1, A=0; bg/ba hold the latched values.
- States: IDLE, ACT, WAIT_RCD, CAS, WAIT_LAT, DATA, WAIT_WR, PRE, WAIT_RP; RC_ACT2 and WAIT_RC exist only with the feature enabled.
- ACT at cycle 1: cs_n=0, act_n=0, A=row.
- CAS at cycle 1+TRCD: cs_n=0, act_n=1, A[16:14]=100 for write or 101 for read, A10=0, A[COLWIDTH-1:0]=col.
- Write data: beats are driven on cycles CAS+TCWL .. CAS+TCWL+BL-1. dq_oe=1, dqs_t=all 1, dqs_c=all 0 during the burst; dqs_t=0 and dqs_c=all 1 otherwise.
- Read data: dq_in is sampled on cycles CAS+TCL .. CAS+TCL+BL-1. rd_data is updated and rd_valid pulses on the cycle after the last beat.
- PRE: cs_n=0, act_n=1, A[16:14]=010, other A bits 0.
  - Write: PRE issues at max(lastbeat+1+TWR, ACT+TRAS).
  - Read: PRE issues at max(lastbeat+1, ACT+TRAS).
  - done pulses in the PRE cycle.
- WAIT_RP: req_ready returns to 1 at PRE+TRAP, i.e. exactly TRP cycles after the PRE cycle.
- Op 00: accepted; err pulses at cycle 1; no commands; req_ready=1 at cycle 1.
- The tRAS counter is independent. If tRAS has already elapsed, no extra wait is inserted.

Optional Feature:
- Macro ROWCLONE_EN.
- Defined, op 11:
  - ACT src row at cycle 1.
  - ACT dst row (req_dst_row) at cycle 1+TRAS, with no intervening PRE.
  - PRE at cycle 1+2*TRAS; done pulses in that cycle.
  - req_ready=1 at 1+2*TRAS+TRP.
  - No CAS issued, no data phase, rd_valid stays 0.
- Undefined: op 11 behaves as op 00 (err pulse at cycle 1, no commands); RC states are not built.

Test Plan:
- Reset held, then released → req_ready=1, cs_n=1, dq_oe=0, dqs_c=all 1.
- Write, bg=1 ba=1 row=1 col=2, defaults:
  - ACT A=0x00001 at cycle 1.
  - CAS A=0x10002 at cycle 16.
  - dq_oe=1 on cycles 28–35 with beats 0–7 in order.
  - PRE A=0x08000 with done at cycle 52.
  - req_ready=1 at cycle 67.
- Read, row=1 col=2, dq_in driven with beat value k on cycles 31+k:
  - CAS A=0x14002 at cycle 16.
  - rd_valid at cycle 39 with rd_data beats 0..7.
  - PRE at cycle 39 (TRAS satisfied).
  - req_ready at cycle 54.
- RowClone with ROWCLONE_EN, row=1, dst=4:
  - ACT A=0x00001 at cycle 1.
  - ACT A=0x00004 at cycle 33.
  - PRE at cycle 65.
  - ready at 80.
  - No CAS; dq_oe never 1.
- Op 00, or op 11 without the macro → err at cycle 1, cs_n stays 1, ready at cycle 1.
- reset_n pulsed low at cycle 30 of a write → dq_oe=0 and req_ready=1 immediately; no done pulse.

Source files
------------

// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer: closed-page DDR4 command sequencer (ACT -> WR/RD -> PRE)
// with write-burst drive and read-burst capture, one transaction at a time.
// Optional in-DRAM RowClone (ACT src, ACT dst, PRE) is built when the
// ROWCLONE_EN macro is defined; otherwise op 11 is rejected like op 00.
module ddr4_cmd_sequencer #(
  parameter int unsigned CHIPS        = 18,
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned BGWIDTH      = 2,
  parameter int unsigned BAWIDTH      = 2,
  parameter int unsigned ADDRWIDTH    = 17,
  parameter int unsigned COLWIDTH     = 10,
  parameter int unsigned BL           = 8,
  parameter int unsigned TRCD         = 15,
  parameter int unsigned TCL          = 15,
  parameter int unsigned TCWL         = 12,
  parameter int unsigned TRAS         = 32,
  parameter int unsigned TWR          = 16,
  parameter int unsigned TRP          = 15
) (
  input  logic                                 ck_t,
  input  logic                                 reset_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [1:0]                           req_op,
  input  logic [BGWIDTH-1:0]                   req_bg,
  input  logic [BAWIDTH-1:0]                   req_ba,
  input  logic [ADDRWIDTH-1:0]                 req_row,
  input  logic [COLWIDTH-1:0]                  req_col,
  input  logic [ADDRWIDTH-1:0]                 req_dst_row,
  input  logic [DEVICE_WIDTH*CHIPS*BL-1:0]     req_wdata,
  output logic                                 rd_valid,
  output logic [DEVICE_WIDTH*CHIPS*BL-1:0]     rd_data,
  output logic                                 done,
  output logic                                 err,
  output logic                                 cs_n,
  output logic                                 act_n,
  output logic [ADDRWIDTH-1:0]                 A,
  output logic [BGWIDTH-1:0]                   bg,
  output logic [BAWIDTH-1:0]                   ba,
  output logic [DEVICE_WIDTH*CHIPS-1:0]        dq_out,
  output logic                                 dq_oe,
  input  logic [DEVICE_WIDTH*CHIPS-1:0]        dq_in,
  output logic [CHIPS-1:0]                     dqs_t,
  output logic [CHIPS-1:0]                     dqs_c
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DQWIDTH  = DEVICE_WIDTH * CHIPS;
  localparam int unsigned BURSTW   = DQWIDTH * BL;
  localparam int unsigned WAIT_MAX = max2(max2(max2(TRCD, TCL), max2(TCWL, TWR)), TRP);
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned RAS_W    = $clog2(TRAS + 1);
  localparam int unsigned BEAT_W   = (BL > 1) ? $clog2(BL) : 1;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
`ifdef ROWCLONE_EN
  localparam logic [1:0] OP_RC = 2'b11;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_WAIT_LAT,
    S_DATA,
    S_WAIT_WR,
    S_PRE,
    S_WAIT_RP
`ifdef ROWCLONE_EN
    ,
    S_RC_ACT2,
    S_WAIT_RC
`endif
  } state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [COLWIDTH-1:0]   r_col;
  logic [BURSTW-1:0]     r_wdata;
  logic [BURSTW-1:0]     r_rd_buf;
  logic [WAIT_W-1:0]     r_wait;
  logic [RAS_W-1:0]      r_ras_cnt;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_rd_pend;
  logic                  r_err_pend;
`ifdef ROWCLONE_EN
  logic [ADDRWIDTH-1:0]  r_dst_row;
`else
  logic                  w_unused_dst;
  assign w_unused_dst = ^req_dst_row;
`endif

  logic                  w_accept;
  logic                  w_op_ok;
  logic                  w_ras_ok;
  logic                  w_last_beat;
  logic [WAIT_W-1:0]     w_lat_m1;
  logic                  w_lat_one;
  logic [ADDRWIDTH-1:0]  w_cas_a;
  logic [ADDRWIDTH-1:0]  w_pre_a;

  assign w_accept    = req_valid && req_ready;
  assign w_ras_ok    = (r_ras_cnt == '0);
  assign w_last_beat = (r_beat == BEAT_W'(BL - 1));
  assign w_lat_m1    = (r_op == OP_WR) ? WAIT_W'(TCWL - 1) : WAIT_W'(TCL - 1);
  assign w_lat_one   = (w_lat_m1 == '0);
  assign w_cas_a     = ADDRWIDTH'({(r_op == OP_WR) ? 3'b100 : 3'b101, 14'b0}) | ADDRWIDTH'(r_col);
  assign w_pre_a     = ADDRWIDTH'(17'h08000);

  // Supported-op decode; RowClone only counts as valid when built in
  always_comb begin
    w_op_ok = (req_op == OP_WR) || (req_op == OP_RD);
`ifdef ROWCLONE_EN
    if (req_op == OP_RC) w_op_ok = 1'b1;
`endif
  end

  // Sequencer FSM with registered pin/handshake outputs
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_row      <= '0;
      r_col      <= '0;
      r_wdata    <= '0;
      r_rd_buf   <= '0;
      r_wait     <= '0;
      r_ras_cnt  <= '0;
      r_beat     <= '0;
      r_rd_pend  <= 1'b0;
      r_err_pend <= 1'b0;
`ifdef ROWCLONE_EN
      r_dst_row  <= '0;
`endif
      req_ready  <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cs_n       <= 1'b1;
      act_n      <= 1'b1;
      A          <= '0;
      bg         <= '0;
      ba         <= '0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      dqs_t      <= '0;
      dqs_c      <= '1;
    end else begin
      cs_n     <= 1'b1;
      act_n    <= 1'b1;
      A        <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      dqs_t    <= '0;
      dqs_c    <= '1;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      // tRAS timer runs on its own from the most recent ACT
      if (r_ras_cnt != '0) r_ras_cnt <= r_ras_cnt - RAS_W'(1);

      // Publish the captured burst the cycle after its last beat
      if (r_rd_pend) begin
        rd_valid  <= 1'b1;
        rd_data   <= r_rd_buf;
        r_rd_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_err_pend) begin
            err        <= 1'b1;
            req_ready  <= 1'b1;
            r_err_pend <= 1'b0;
          end else if (w_accept) begin
            r_op      <= req_op;
            r_row     <= req_row;
            r_col     <= req_col;
            r_wdata   <= req_wdata;
`ifdef ROWCLONE_EN
            r_dst_row <= req_dst_row;
`endif
            bg        <= req_bg;
            ba        <= req_ba;
            req_ready <= 1'b0;
            if (w_op_ok) r_state <= S_ACT;
            else         r_err_pend <= 1'b1;
          end
        end

        S_ACT: begin
          cs_n      <= 1'b0;
          act_n     <= 1'b0;
          A         <= r_row;
          r_ras_cnt <= RAS_W'(TRAS - 1);
`ifdef ROWCLONE_EN
          if (r_op == OP_RC) begin
            if (TRAS > 1) r_state <= S_WAIT_RC;
            else          r_state <= S_RC_ACT2;
          end else
`endif
          if (TRCD == 1) begin
            r_state <= S_CAS;
          end else begin
            r_wait  <= WAIT_W'(TRCD - 1);
            r_state <= S_WAIT_RCD;
          end
        end

        S_WAIT_RCD: begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) r_state <= S_CAS;
        end

        S_CAS: begin
          cs_n   <= 1'b0;
          A      <= w_cas_a;
          r_beat <= '0;
          if (w_lat_one) begin
            r_state <= S_DATA;
          end else begin
            r_wait  <= w_lat_m1;
            r_state <= S_WAIT_LAT;
          end
        end

        S_WAIT_LAT: begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) r_state <= S_DATA;
        end

        S_DATA: begin
          if (r_op == OP_WR) begin
            dq_out <= r_wdata[r_beat*DQWIDTH +: DQWIDTH];
            dq_oe  <= 1'b1;
            dqs_t  <= '1;
            dqs_c  <= '0;
          end else begin
            r_rd_buf[r_beat*DQWIDTH +: DQWIDTH] <= dq_in;
          end
          if (w_last_beat) begin
            r_beat <= '0;
            if (r_op == OP_WR) begin
              if (TWR == 0) begin
                r_state <= S_PRE;
              end else begin
                r_wait  <= WAIT_W'(TWR);
                r_state <= S_WAIT_WR;
              end
            end else begin
              r_rd_pend <= 1'b1;
              r_state   <= S_PRE;
            end
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
          end
        end

        S_WAIT_WR: begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) r_state <= S_PRE;
        end

        S_PRE: begin
          if (w_ras_ok) begin
            cs_n <= 1'b0;
            A    <= w_pre_a;
            done <= 1'b1;
            if (TRP == 0) begin
              req_ready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_wait  <= WAIT_W'(TRP);
              r_state <= S_WAIT_RP;
            end
          end
        end

        S_WAIT_RP: begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) begin
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

`ifdef ROWCLONE_EN
        S_WAIT_RC: begin
          if (r_ras_cnt <= RAS_W'(1)) r_state <= S_RC_ACT2;
        end

        S_RC_ACT2: begin
          cs_n      <= 1'b0;
          act_n     <= 1'b0;
          A         <= r_dst_row;
          r_ras_cnt <= RAS_W'(TRAS - 1);
          r_state   <= S_PRE;
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
